// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   8N1 UART receiver followed by a small show-ahead byte FIFO. The receiver
//   synchronises the raw line, qualifies the start bit at its midpoint,
//   samples each data bit mid-cell (LSB first), and checks the stop bit.
//   A good byte is pushed into the FIFO. A bad stop bit produces a single
//   frame_err pulse. A good byte that finds the FIFO full produces an overrun
//   pulse and is dropped.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   rx         in   raw serial input, idle high
//   rx_data    out  FIFO head byte (holds the last popped byte when empty)
//   rx_valid   out  FIFO not empty
//   rx_ready   in   consumer accepts the head byte (pop = rx_valid & rx_ready)
//   frame_err  out  one-cycle pulse: sampled stop bit was 0
//   overrun    out  one-cycle pulse: good byte dropped, FIFO full
//   busy       out  receiver FSM not idle (one cycle behind the FSM)
//   fifo_count out  number of stored bytes
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rx,
  output logic [7:0]                         rx_data,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic                               frame_err,
  output logic                               overrun,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser; both flops reset to the idle (high) line level so a
  // reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic rx_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push;
  logic          ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // the pre-edge values; blocking (=) here would create ordering races.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case below can leave a signal unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end

      S_START: begin
        // Re-check the line at the middle of the start bit; a high level
        // means the falling edge was a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end

      S_STOP: begin
        // Leaving at mid stop bit re-arms for a back-to-back start edge.
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end

      S_WAIT_HIGH: begin
        // A break holds the line low; wait it out so it flags only once.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO: pointers carry one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [7:0]    last_q;
  logic          empty;
  logic          full;
  logic          pop;
  logic          do_write;
  logic          ovr_d;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = wr_q[AW-1:0];
  assign rd_idx = rd_q[AW-1:0];
  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_idx == rd_idx);
  assign pop    = !empty && rx_ready;

  // A pop in the same cycle frees the slot the push needs.
  assign do_write = push && (!full || pop);
  assign ovr_d    = push && full && !pop;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_write) wr_d = wr_q + PTR_ONE;
    if (pop)      rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      last_q    <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      if (pop) last_q <= mem[rd_idx];
      frame_err <= ferr_d;
      overrun   <= ovr_d;
      busy      <= (state_q != S_IDLE);
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers alone, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_idx] <= shift_q;
  end

  assign rx_valid   = !empty;
  assign rx_data    = empty ? last_q : mem[rd_idx];
  assign fifo_count = wr_q - rd_q;

endmodule
